core_seq: RTL and testbench

Multi-cycle sequencer for the RV32 core datapath. It fetches each instruction over a req/ack instruction-memory handshake and latches it for the decode/ALU/register-file path. It gates the register-file write enable to one cycle per instruction, holds load/store instructions until the data-memory handshake completes, and advances the PC. It sits between the PC/instruction memory and the control unit, replacing free-running PC stepping with handshake-driven control.

---
 rtl/core_seq_pkg.sv | 22 ++
 rtl/core_seq_wait_timer.sv | 33 +++
 rtl/core_seq.sv | 140 ++++++++++++++
 tb/tb_core_seq.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_seq_pkg.sv
// Shared definitions for the core sequencer: state encoding, reset constants
// and a small helper used by the FSM and its wait timer.
package core_defs;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_HALT  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h8000_0000;

    // States in which the sequencer is blocked on an external acknowledge.
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/core_seq_wait_timer.sv
// Acknowledge wait counter: counts un-acked wait cycles and flags when the
// count has reached TIMEOUT. TIMEOUT of 0 disables expiry.
module wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;
    logic          w_at_limit;

    assign w_at_limit = (r_cnt == CW'(TIMEOUT));

    // Saturate at the limit so a disabled timer never wraps.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_at_limit) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expired = (TIMEOUT != 0) && w_at_limit;

endmodule

// File: rtl/core_seq.sv
// Handshake-driven multi-cycle sequencer: fetch, execute, optional data-memory
// wait, retire. Owns the PC, instruction latch and retire counter.
module core_seq
    import core_defs::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    input  logic [31:0] npc_i,
    input  logic        is_mem_i,
    input  logic        halt_i,
    input  logic        rd_wen_i,
    output logic        rd_wen_o,
    output logic        dmem_req_o,
    input  logic        dmem_ack_i,
    output logic        retire_o,
    output logic [31:0] retire_cnt_o,
    output logic        halted_o,
    output logic        err_o
);

    state_t      r_state;
    state_t      w_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_retire_cnt;

    logic w_wait;
    logic w_ack;
    logic w_expired;
    logic w_latch;
    logic w_retire;
    logic w_wen;
    logic w_pc_load;

    assign w_wait = is_wait_state(r_state);

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_clr     (!w_wait || w_ack),
        .i_en      (w_wait),
        .o_expired (w_expired)
    );

    // An ack always takes priority over an expiring timer in the same cycle.
    always_comb begin
        w_nxt     = r_state;
        w_ack     = 1'b0;
        w_latch   = 1'b0;
        w_retire  = 1'b0;
        w_wen     = 1'b0;
        w_pc_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                w_ack = imem_ack_i;
                if (imem_ack_i) begin
                    w_latch = 1'b1;
                    w_nxt   = ST_EXEC;
                end else if (w_expired) begin
                    w_nxt = ST_ERR;
                end
            end
            ST_EXEC: begin
                if (halt_i) begin
                    w_retire = 1'b1;
                    w_nxt    = ST_HALT;
                end else if (is_mem_i) begin
                    w_nxt = ST_MEM;
                end else begin
                    w_retire  = 1'b1;
                    w_wen     = rd_wen_i;
                    w_pc_load = 1'b1;
                    w_nxt     = ST_FETCH;
                end
            end
            ST_MEM: begin
                w_ack = dmem_ack_i;
                if (dmem_ack_i) begin
                    w_retire  = 1'b1;
                    w_wen     = rd_wen_i;
                    w_pc_load = 1'b1;
                    w_nxt     = ST_FETCH;
                end else if (w_expired) begin
                    w_nxt = ST_ERR;
                end
            end
            ST_HALT: w_nxt = ST_HALT;
            ST_ERR:  w_nxt = ST_ERR;
            default: w_nxt = ST_IDLE;
        endcase
    end

    // A cycle in which reset is asserted never retires or writes.
    assign retire_o = w_retire && rst;
    assign rd_wen_o = w_wen && rst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_pc         <= PC_RESET;
            r_inst       <= NOP_INST;
            r_retire_cnt <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_latch) begin
                r_inst <= imem_rdata_i;
            end
            if (w_pc_load) begin
                r_pc <= npc_i;
            end
            if (retire_o) begin
                r_retire_cnt <= r_retire_cnt + 32'd1;
            end
        end
    end

    assign imem_req_o   = (r_state == ST_FETCH);
    assign imem_addr_o  = r_pc;
    assign pc_o         = r_pc;
    assign inst_o       = r_inst;
    assign dmem_req_o   = (r_state == ST_MEM);
    assign halted_o     = (r_state == ST_HALT);
    assign err_o        = (r_state == ST_ERR);
    assign retire_cnt_o = r_retire_cnt;

endmodule

// File: tb/tb_core_seq.sv
// Randomised scoreboard bench for core_seq: a driver plays instruction/data
// memory and control unit, a negedge monitor checks every retirement.
module tb_core_seq;

    localparam logic [31:0] PC_RST = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          TO     = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [31:0] npc_i = '0;
    logic        is_mem_i = 1'b0;
    logic        halt_i = 1'b0;
    logic        rd_wen_i = 1'b0;
    logic        rd_wen_o;
    logic        dmem_req_o;
    logic        dmem_ack_i = 1'b0;
    logic        retire_o;
    logic [31:0] retire_cnt_o;
    logic        halted_o;
    logic        err_o;

    always #5 clk = ~clk;

    core_seq #(
        .PC_RESET (PC_RST),
        .TIMEOUT  (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .inst_o       (inst_o),
        .pc_o         (pc_o),
        .npc_i        (npc_i),
        .is_mem_i     (is_mem_i),
        .halt_i       (halt_i),
        .rd_wen_i     (rd_wen_i),
        .rd_wen_o     (rd_wen_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_ack_i   (dmem_ack_i),
        .retire_o     (retire_o),
        .retire_cnt_o (retire_cnt_o),
        .halted_o     (halted_o),
        .err_o        (err_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        wen;
        logic [31:0] cnt;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] m_pc = PC_RST;
    logic [31:0] m_cnt = '0;
    int          m_start = 1;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitor: cycle 0 is the first cycle with rst released (the IDLE cycle).
    always @(negedge clk) begin
        if (!rst) begin
            cyc = 0;
        end else begin
            if (rd_wen_o) chk1("rd_wen_only_on_retire", retire_o, 1'b1);
            if (retire_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_retire: got retire at pc %h expected none", pc_o);
                end else begin
                    mon_e = sb.pop_front();
                    chk32("retire_pc", pc_o, mon_e.pc);
                    chk32("retire_inst", inst_o, mon_e.inst);
                    chk1("retire_wen", rd_wen_o, mon_e.wen);
                    chk32("retire_cnt", retire_cnt_o, mon_e.cnt);
                    checks++;
                    if (cyc != mon_e.cyc) begin
                        errors++;
                        $display("FAIL retire_cycle: got %0d expected %0d", cyc, mon_e.cyc);
                    end
                end
            end
            cyc++;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_inst(input logic [31:0] inst, input int d, input logic [31:0] addr);
        int w = 0;
        while (!imem_req_o && w < 10) begin
            next_cycle();
            w++;
        end
        chk1("fetch_req", imem_req_o, 1'b1);
        for (int k = 0; k < d; k++) begin
            imem_ack_i   = 1'b0;
            imem_rdata_i = $urandom;
            chk32("fetch_addr_stable", imem_addr_o, addr);
            next_cycle();
        end
        imem_ack_i   = 1'b1;
        imem_rdata_i = inst;
        next_cycle();
        imem_ack_i   = 1'b0;
        imem_rdata_i = $urandom;
    endtask

    task automatic do_instr(input int d, input int m, input bit mem, input bit halt,
                            input bit wen, input logic [31:0] npc);
        logic [31:0] inst = $urandom;
        exp_t        e;
        int          ret;
        ret    = m_start + d + 1 + ((mem && !halt) ? (m + 1) : 0);
        e.pc   = m_pc;
        e.inst = inst;
        e.wen  = wen && !halt;
        e.cnt  = m_cnt;
        e.cyc  = ret;
        sb.push_back(e);
        fetch_inst(inst, d, m_pc);
        halt_i   = halt;
        is_mem_i = mem;
        rd_wen_i = wen;
        npc_i    = npc;
        next_cycle();
        if (mem && !halt) begin
            for (int k = 0; k < m; k++) begin
                dmem_ack_i = 1'b0;
                chk1("mem_req", dmem_req_o, 1'b1);
                chk32("mem_pc_hold", pc_o, e.pc);
                next_cycle();
            end
            dmem_ack_i = 1'b1;
            next_cycle();
            dmem_ack_i = 1'b0;
        end
        halt_i   = 1'b0;
        is_mem_i = 1'b0;
        rd_wen_i = 1'b0;
        npc_i    = $urandom;
        m_start  = ret + 1;
        m_cnt    = m_cnt + 32'd1;
        if (!halt) begin
            m_pc = npc;
            chk32("pc_after_retire", pc_o, npc);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        imem_ack_i = 1'b0;
        dmem_ack_i = 1'b0;
        halt_i     = 1'b0;
        is_mem_i   = 1'b0;
        rd_wen_i   = 1'b0;
        next_cycle();
        next_cycle();
        chk1("rst_imem_req", imem_req_o, 1'b0);
        chk1("rst_dmem_req", dmem_req_o, 1'b0);
        chk32("rst_pc", pc_o, PC_RST);
        chk32("rst_inst", inst_o, NOP);
        chk32("rst_retire_cnt", retire_cnt_o, 32'd0);
        chk1("rst_halted", halted_o, 1'b0);
        chk1("rst_err", err_o, 1'b0);
        chk1("rst_retire", retire_o, 1'b0);
        chk1("rst_rd_wen", rd_wen_o, 1'b0);
        rst = 1'b1;
        sb.delete();
        m_pc    = PC_RST;
        m_cnt   = '0;
        m_start = 1;
        chk1("idle_no_req", imem_req_o, 1'b0);
        next_cycle();
        chk1("first_req", imem_req_o, 1'b1);
        chk32("first_addr", imem_addr_o, PC_RST);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int          k;
        logic [31:0] npc;
        do_reset();

        // Back-to-back single-cycle acks: one retire every two cycles.
        for (int i = 0; i < 5; i++) do_instr(0, 0, 1'b0, 1'b0, 1'b1, m_pc + 32'd4);

        for (int i = 0; i < 40; i++) begin
            npc = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : (m_pc + 32'd4);
            do_instr($urandom_range(0, TO), $urandom_range(0, TO),
                     ($urandom_range(0, 2) == 0), 1'b0, $urandom_range(0, 1) == 1, npc);
        end

        // Reset pulsed while waiting in MEM.
        fetch_inst($urandom, 0, m_pc);
        is_mem_i = 1'b1;
        rd_wen_i = 1'b1;
        npc_i    = m_pc + 32'd4;
        next_cycle();
        chk1("mem_req_before_rst", dmem_req_o, 1'b1);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        chk1("mem_rst_dmem_req", dmem_req_o, 1'b0);
        chk32("mem_rst_pc", pc_o, PC_RST);
        chk32("mem_rst_cnt", retire_cnt_o, 32'd0);
        chk1("mem_rst_retire", retire_o, 1'b0);
        rst      = 1'b1;
        is_mem_i = 1'b0;
        rd_wen_i = 1'b0;
        sb.delete();
        m_pc    = PC_RST;
        m_cnt   = '0;
        m_start = 1;
        chk1("mem_rst_idle", imem_req_o, 1'b0);
        next_cycle();
        chk1("mem_rst_fetch_resume", imem_req_o, 1'b1);

        do_instr(1, 0, 1'b0, 1'b0, 1'b1, m_pc + 32'd4);

        // halt_i and is_mem_i together: halt wins, no memory access.
        do_instr(1, 0, 1'b1, 1'b1, 1'b1, $urandom);
        for (int i = 0; i < 5; i++) begin
            imem_ack_i = 1'b1;
            dmem_ack_i = 1'b1;
            chk1("halt_halted", halted_o, 1'b1);
            chk1("halt_no_dmem_req", dmem_req_o, 1'b0);
            chk1("halt_no_imem_req", imem_req_o, 1'b0);
            chk32("halt_cnt_frozen", retire_cnt_o, m_cnt);
            next_cycle();
        end
        imem_ack_i = 1'b0;
        dmem_ack_i = 1'b0;

        // Ack arriving exactly when the timer reaches TIMEOUT still wins.
        do_reset();
        chk1("halt_cleared", halted_o, 1'b0);
        do_instr(TO, 0, 1'b0, 1'b0, 1'b1, m_pc + 32'd4);
        chk1("ack_at_limit_no_err", err_o, 1'b0);

        // No ack at all: FETCH lasts TIMEOUT+1 cycles then ERR.
        k = 0;
        while (!err_o && k < 20) begin
            next_cycle();
            k++;
        end
        chk32("timeout_fetch_cycles", 32'(k), 32'(TO + 1));
        for (int i = 0; i < 3; i++) begin
            imem_ack_i = 1'b1;
            chk1("err_sticky", err_o, 1'b1);
            chk1("err_no_req", imem_req_o, 1'b0);
            next_cycle();
        end
        imem_ack_i = 1'b0;
        chk32("err_cnt_frozen", retire_cnt_o, m_cnt);

        chk32("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
